// File: rtl/stream_upsizer.sv
// stream_upsizer: packs RATIO narrow beats into one wide word with lane keep mask.
// Optional idle-flush of partial words when STREAM_UPSIZER_TIMEOUT_EN is defined.
module stream_upsizer #(
  parameter int N       = 32,
  parameter int RATIO   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_valid,
  input  logic [N-1:0]         s_data,
  input  logic                 s_last,
  output logic                 s_ready,
  output logic                 m_valid,
  output logic [N*RATIO-1:0]   m_data,
  output logic [RATIO-1:0]     m_keep,
  output logic                 m_last,
  input  logic                 m_ready
);
  localparam int IW = $clog2(RATIO);

  if (RATIO < 2 || RATIO > 16 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_param
    $error("stream_upsizer: RATIO or TIMEOUT out of range");
  end

  logic [IW-1:0]      r_idx;
  logic [N-1:0]       r_acc [RATIO-1];
  logic               r_m_valid;
  logic [N*RATIO-1:0] r_m_data;
  logic [RATIO-1:0]   r_m_keep;
  logic               r_m_last;
  logic               w_beat;
  logic               w_close;
  logic               w_flush;
  logic               w_load;
  logic [N*RATIO-1:0] w_data;
  logic [RATIO-1:0]   w_keep;

  assign s_ready = ~r_m_valid | m_ready;
  assign w_beat  = s_valid & s_ready;
  assign w_close = w_beat & (s_last | (r_idx == IW'(RATIO-1)));
  assign w_load  = w_close | w_flush;
  assign m_valid = r_m_valid;
  assign m_data  = r_m_data;
  assign m_keep  = r_m_keep;
  assign m_last  = r_m_last;

  // Lanes below the index come from the accumulator; the closing beat lands at the index.
  for (genvar i = 0; i < RATIO; i++) begin : g_lane
    assign w_keep[i] = (IW'(i) < r_idx) | (w_close & (IW'(i) == r_idx));
    if (i < RATIO-1) begin : g_acc
      always_ff @(posedge clk)
        if (w_beat && !w_close && r_idx == IW'(i)) r_acc[i] <= s_data;
      assign w_data[i*N +: N] = !w_keep[i] ? '0 : (IW'(i) < r_idx) ? r_acc[i] : s_data;
    end else begin : g_top
      assign w_data[i*N +: N] = w_keep[i] ? s_data : '0;
    end
  end

`ifdef STREAM_UPSIZER_TIMEOUT_EN
  logic [7:0] r_cnt;
  assign w_flush = ~w_beat & s_ready & (r_idx != '0) & (r_cnt == 8'(TIMEOUT));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_cnt <= '0;
    else r_cnt <= (w_beat || r_idx == '0 || w_flush) ? '0 :
                  (r_cnt == 8'(TIMEOUT)) ? r_cnt : r_cnt + 8'd1;
`else
  assign w_flush = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_m_keep  <= '0;
      r_m_last  <= 1'b0;
      r_idx     <= '0;
    end else begin
      if (w_load) begin
        r_m_valid <= 1'b1;
        r_m_data  <= w_data;
        r_m_keep  <= w_keep;
        r_m_last  <= w_close & s_last;
      end else if (m_ready) begin
        r_m_valid <= 1'b0;
      end
      r_idx <= w_load ? '0 : w_beat ? r_idx + IW'(1) : r_idx;
    end
endmodule

// File: tb/tb_stream_upsizer.sv
// tb_stream_upsizer: directed vector table, reset/streaming sequences and a
// randomized run against a queue-based reference model.
module tb_stream_upsizer;
  localparam int N = 32, R = 4, T = 16, W = N*R;
  localparam logic H = 1'b1, L = 1'b0;

  logic clk = 1'b0, rst_n = 1'b0, s_valid = 1'b0, s_last = 1'b0, m_ready = 1'b0;
  logic [N-1:0] s_data = '0;
  logic s_ready, m_valid, m_last;
  logic [W-1:0] m_data;
  logic [R-1:0] m_keep;

  stream_upsizer #(.N(N), .RATIO(R), .TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
    .s_ready(s_ready), .m_valid(m_valid), .m_data(m_data), .m_keep(m_keep),
    .m_last(m_last), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [N-1:0] d, input logic l, input logic mr);
    s_valid = v; s_data = d; s_last = l; m_ready = mr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic v; logic [N-1:0] d; logic l; logic mr;
    logic sr; logic mv; logic [W-1:0] md; logic [R-1:0] mk; logic ml;
  } vec_t;

  function automatic vec_t mkv(input logic v, input logic [N-1:0] d, input logic l, input logic mr,
                               input logic sr, input logic mv, input logic [W-1:0] md,
                               input logic [R-1:0] mk, input logic ml);
    vec_t x;
    x.v = v; x.d = d; x.l = l; x.mr = mr; x.sr = sr; x.mv = mv; x.md = md; x.mk = mk; x.ml = ml;
    return x;
  endfunction

  // Reference model: beats queue up until s_last or RATIO beats, then form one word.
  logic [N-1:0] q[$];
  logic exp_v = 1'b0, exp_l = 1'b0;
  logic [W-1:0] exp_d = '0;
  logic [R-1:0] exp_k = '0;
  int cnt = 0;

  task automatic form_word();
    exp_d = '0; exp_k = '0;
    foreach (q[i]) begin
      exp_d[i*N +: N] = q[i];
      exp_k[i] = 1'b1;
    end
    exp_v = 1'b1;
    q.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  vec_t tbl[17];

  initial begin
    tbl[0]  = mkv(H, 32'h11, L, H, H, L, '0, '0, L);
    tbl[1]  = mkv(H, 32'h22, L, H, H, L, '0, '0, L);
    tbl[2]  = mkv(H, 32'h33, L, H, H, L, '0, '0, L);
    tbl[3]  = mkv(H, 32'h44, H, H, H, H, {32'h44, 32'h33, 32'h22, 32'h11}, 4'hF, H);
    tbl[4]  = mkv(H, 32'hA1, L, H, H, L, '0, '0, L);
    tbl[5]  = mkv(H, 32'hA2, H, H, H, H, {64'h0, 32'hA2, 32'hA1}, 4'h3, H);
    tbl[6]  = mkv(H, 32'hB1, L, L, L, H, {64'h0, 32'hA2, 32'hA1}, 4'h3, H);
    tbl[7]  = mkv(H, 32'hB1, H, L, L, H, {64'h0, 32'hA2, 32'hA1}, 4'h3, H);
    tbl[8]  = mkv(H, 32'hB1, H, H, H, H, {96'h0, 32'hB1}, 4'h1, H);
    tbl[9]  = mkv(L, 32'h0,  L, L, L, H, {96'h0, 32'hB1}, 4'h1, H);
    tbl[10] = mkv(L, 32'h0,  L, H, H, L, '0, '0, L);
    tbl[11] = mkv(H, 32'hC1, L, H, H, L, '0, '0, L);
    tbl[12] = mkv(H, 32'hC2, L, H, H, L, '0, '0, L);
    tbl[13] = mkv(H, 32'hC3, L, H, H, L, '0, '0, L);
    tbl[14] = mkv(H, 32'hC4, L, H, H, H, {32'hC4, 32'hC3, 32'hC2, 32'hC1}, 4'hF, L);
    tbl[15] = mkv(H, 32'hD1, L, L, L, H, {32'hC4, 32'hC3, 32'hC2, 32'hC1}, 4'hF, L);
    tbl[16] = mkv(H, 32'hD1, L, H, H, L, '0, '0, L);

    #2;
    chk("rst_m_valid", W'(m_valid), W'(0));
    chk("rst_m_keep", W'(m_keep), W'(0));
    chk("rst_m_last", W'(m_last), W'(0));
    chk("rst_m_data", m_data, '0);
    chk("rst_s_ready", W'(s_ready), W'(1));
    rst_n = 1'b1;
    tick();

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].mr);
      #1;
      chk($sformatf("vec%0d_s_ready", i), W'(s_ready), W'(tbl[i].sr));
      tick();
      chk($sformatf("vec%0d_m_valid", i), W'(m_valid), W'(tbl[i].mv));
      if (tbl[i].mv) begin
        chk($sformatf("vec%0d_m_data", i), m_data, tbl[i].md);
        chk($sformatf("vec%0d_m_keep", i), W'(m_keep), W'(tbl[i].mk));
        chk($sformatf("vec%0d_m_last", i), W'(m_last), W'(tbl[i].ml));
      end
    end

    // Reset mid-packet with a pending word: everything discarded.
    drive(H, 32'hE2, L, H); tick();
    drive(H, 32'hE3, H, L); tick();
    drive(L, 32'h0, L, L);
    rst_n = 1'b0;
    #1;
    chk("midrst_m_valid", W'(m_valid), W'(0));
    chk("midrst_m_keep", W'(m_keep), W'(0));
    chk("midrst_s_ready", W'(s_ready), W'(1));
    tick();
    chk("midrst_hold_m_data", m_data, '0);
    rst_n = 1'b1;
    tick();
    chk("postrst_s_ready", W'(s_ready), W'(1));
    for (int k = 0; k < 4; k++) begin
      drive(H, 32'hF1 + k, L, H);
      tick();
      chk($sformatf("fresh%0d_m_valid", k), W'(m_valid), W'(k == 3));
    end
    chk("fresh_m_keep", W'(m_keep), W'(4'hF));
    chk("fresh_m_data", m_data, {32'hF4, 32'hF3, 32'hF2, 32'hF1});
    chk("fresh_m_last", W'(m_last), W'(0));
    drive(L, 32'h0, L, H); tick();

    // Continuous streaming: 12 beats, one word every 4 cycles, s_ready always high.
    begin
      int words = 0;
      for (int k = 0; k < 12; k++) begin
        drive(H, 32'h100 + k, L, H);
        #1;
        chk($sformatf("stream%0d_s_ready", k), W'(s_ready), W'(1));
        tick();
        chk($sformatf("stream%0d_m_valid", k), W'(m_valid), W'(k % 4 == 3));
        if (m_valid) begin
          words++;
          chk($sformatf("stream%0d_m_data", k), m_data,
              {32'h100 + k, 32'h100 + k - 1, 32'h100 + k - 2, 32'h100 + k - 3});
        end
      end
      chk("stream_words", W'(words), W'(3));
    end
    drive(L, 32'h0, L, H); tick();

`ifdef STREAM_UPSIZER_TIMEOUT_EN
    do_reset();
    begin
      int wait_cyc = 0;
      for (int k = 0; k < 3; k++) begin drive(H, 32'h1 + k, L, H); tick(); end
      drive(L, 32'h0, L, H);
      while (!m_valid && wait_cyc < 40) begin tick(); wait_cyc++; end
      chk("flush_delay", W'(wait_cyc), W'(T + 1));
      chk("flush_m_keep", W'(m_keep), W'(4'h7));
      chk("flush_m_last", W'(m_last), W'(0));
      chk("flush_m_data", m_data, {64'h0, 32'h3, 32'h2, 32'h1});
      tick();
      for (int k = 0; k < 3; k++) begin drive(H, 32'h5 + k, L, H); tick(); end
      drive(L, 32'h0, L, H);
      for (int k = 0; k < T; k++) tick();
      chk("prio_no_early_flush", W'(m_valid), W'(0));
      drive(H, 32'h8, L, H); tick();
      chk("prio_m_valid", W'(m_valid), W'(1));
      chk("prio_m_keep", W'(m_keep), W'(4'hF));
      chk("prio_m_data", m_data, {32'h8, 32'h7, 32'h6, 32'h5});
      drive(L, 32'h0, L, H); tick();
    end
`endif

    // Randomized run against the reference model.
    do_reset();
    q.delete(); exp_v = 1'b0; cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      logic acc, rdy, flush;
      int old_size;
      drive($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 7) == 0, $urandom_range(0, 9) < 7);
      #1;
      rdy = !exp_v || m_ready;
      chk("rand_s_ready", W'(s_ready), W'(rdy));
      acc = s_valid && rdy;
      old_size = q.size();
      flush = 1'b0;
`ifdef STREAM_UPSIZER_TIMEOUT_EN
      flush = !acc && old_size > 0 && cnt == T && rdy;
      cnt = (acc || old_size == 0 || flush) ? 0 : (cnt == T ? T : cnt + 1);
`endif
      if (exp_v && m_ready) exp_v = 1'b0;
      if (acc) begin
        q.push_back(s_data);
        if (s_last || q.size() == R) begin
          exp_l = s_last;
          form_word();
        end
      end else if (flush) begin
        exp_l = 1'b0;
        form_word();
      end
      tick();
      chk("rand_m_valid", W'(m_valid), W'(exp_v));
      if (exp_v) begin
        chk("rand_m_data", m_data, exp_d);
        chk("rand_m_keep", W'(m_keep), W'(exp_k));
        chk("rand_m_last", W'(m_last), W'(exp_l));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
